// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the multicycle MIPS controller:
//   - controller state encoding
//   - opcode / funct constants decoded by the controller
//   - aluop, alucontrol, alusrcb and pcsrc encodings
//   - ctrl_t: the Moore control word held for each state, and the
//     function that maps a state to its control word
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_SIMM   = 2'b10;
    localparam logic [1:0] SRCB_SIMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control word that depends on state alone. pcWrite and retire are the
    // unconditional parts; FETCH and MEMWR add input-qualified terms later.
    typedef struct packed {
        logic       memReq;
        logic       iord;
        logic       memWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic [1:0] aluOp;
        logic       branch;
        logic       pcWrite;
        logic       retire;
        logic       isFetch;
    } ctrl_t;

    function automatic ctrl_t stateControls(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memReq  = 1'b1;
                c.aluSrcB = SRCB_FOUR;
                c.aluOp   = ALUOP_ADD;
                c.isFetch = 1'b1;
            end
            S_DECODE: begin
                c.aluSrcB = SRCB_SIMMSH;
                c.aluOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_SIMM;
            end
            S_MEMRD: begin
                c.memReq = 1'b1;
                c.iord   = 1'b1;
            end
            S_MEMWB: begin
                c.regWrite = 1'b1;
                c.memToReg = 1'b1;
                c.retire   = 1'b1;
            end
            S_MEMWR: begin
                c.memReq   = 1'b1;
                c.iord     = 1'b1;
                c.memWrite = 1'b1;
            end
            S_EXECUTE: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_B;
                c.aluOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regWrite = 1'b1;
                c.regDst   = 1'b1;
                c.retire   = 1'b1;
            end
            S_BRANCH: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_B;
                c.aluOp   = ALUOP_SUB;
                c.pcSrc   = PCSRC_ALUOUT;
                c.branch  = 1'b1;
                c.retire  = 1'b1;
            end
            S_ADDIEX: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = SRCB_SIMM;
                c.aluOp   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                c.regWrite = 1'b1;
                c.retire   = 1'b1;
            end
            S_JUMP: begin
                c.pcSrc   = PCSRC_JUMP;
                c.pcWrite = 1'b1;
                c.retire  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
// Bundle between the controller, the datapath and the memory port.
//   Datapath -> controller : op, funct, zero
//   Memory   -> controller : mem_ready
//   Controller -> memory   : mem_req, iord, memwrite
//   Controller -> datapath : irwrite, regdst, memtoreg, regwrite, alusrca,
//                            alusrcb, pcsrc, pcen, alucontrol
//   Status                 : retire (instruction done), fault (sticky error)
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       retire;
    logic       fault;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, retire, fault
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, retire, fault
    );
endinterface

// File: rtl/multicycle_controller_aludec.sv
// alu_control_decoder
// Purely combinational ALU decoder.
//   aluop_i      [1:0] operation class from the controller
//   funct_i      [5:0] instr[5:0], used only for R-type
//   alucontrol_o [2:0] operation for the shared ALU
module alu_control_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alucontrol_o
);

    // Unknown funct codes fall back to AND so the ALU never sees an
    // undefined operation; the unused aluop 11 behaves like add.
    always_comb begin
        alucontrol_o = ALUCTL_ADD;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALUCTL_ADD;
            ALUOP_SUB: alucontrol_o = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alucontrol_o = ALUCTL_ADD;
                    FUNCT_SUB: alucontrol_o = ALUCTL_SUB;
                    FUNCT_AND: alucontrol_o = ALUCTL_AND;
                    FUNCT_OR:  alucontrol_o = ALUCTL_OR;
                    FUNCT_SLT: alucontrol_o = ALUCTL_SLT;
                    default:   alucontrol_o = ALUCTL_AND;
                endcase
            end
            default: alucontrol_o = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore sequencer for the multicycle MIPS datapath (shared ALU, unified
// instruction/data memory). One state per cycle, stalls on mem_ready,
// flags illegal opcodes and memory timeouts with a sticky fault.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : multicycle_controller_if.master (op/funct/zero/mem_ready in,
//           all datapath enables, mux selects, retire and fault out)
// TIMEOUT_CYCLES = max not-ready cycles per access (0 disables the check),
// TO_W = timeout counter width.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    state_t            state_q, state_d;
    logic   [TO_W-1:0] timeoutCnt_q, timeoutCnt_d;
    logic              fault_q;
    ctrl_t             ctrl_q;
    logic              isWait;
    logic              fetchDone;
    logic   [2:0]      aluCtl;

    assign isWait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    // Next-state and timeout logic. A not-ready wait cycle bumps the counter;
    // the cycle that brings it to TIMEOUT_CYCLES diverts to HALT, but a ready
    // on that same cycle completes the access instead. Any state change
    // clears the counter, so every wait state starts counting from zero.
    always_comb begin
        state_d      = state_q;
        timeoutCnt_d = timeoutCnt_q;
        case (state_q)
            S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_HALT;
        endcase
        if (isWait && !bus.mem_ready) begin
            timeoutCnt_d = timeoutCnt_q + 1'b1;
            if ((TIMEOUT_CYCLES != 0) && (timeoutCnt_d == TO_W'(TIMEOUT_CYCLES))) begin
                state_d = S_HALT;
            end
        end
        if (state_d != state_q) begin
            timeoutCnt_d = '0;
        end
    end

    // State, counter, sticky fault and the registered Moore control word.
    // The control word is loaded with the decode of the next state so it is
    // always the decode of the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            timeoutCnt_q <= '0;
            fault_q      <= 1'b0;
            ctrl_q       <= stateControls(S_FETCH);
        end else begin
            state_q      <= state_d;
            timeoutCnt_q <= timeoutCnt_d;
            ctrl_q       <= stateControls(state_d);
            if (state_d == S_HALT) begin
                fault_q <= 1'b1;
            end
        end
    end

    alu_control_decoder u_aluDec (
        .aluop_i      (ctrl_q.aluOp),
        .funct_i      (bus.funct),
        .alucontrol_o (aluCtl)
    );

    // Everything is gated with reset so strobes drop the moment reset goes
    // low, even mid-access, without waiting for a clock edge.
    assign fetchDone      = ctrl_q.isFetch & bus.mem_ready;
    assign bus.mem_req    = reset & ctrl_q.memReq;
    assign bus.iord       = reset & ctrl_q.iord;
    assign bus.memwrite   = reset & ctrl_q.memWrite;
    assign bus.irwrite    = reset & fetchDone;
    assign bus.regdst     = reset & ctrl_q.regDst;
    assign bus.memtoreg   = reset & ctrl_q.memToReg;
    assign bus.regwrite   = reset & ctrl_q.regWrite;
    assign bus.alusrca    = reset & ctrl_q.aluSrcA;
    assign bus.alusrcb    = reset ? ctrl_q.aluSrcB : 2'b00;
    assign bus.pcsrc      = reset ? ctrl_q.pcSrc : 2'b00;
    assign bus.pcen       = reset & (ctrl_q.pcWrite | fetchDone | (ctrl_q.branch & bus.zero));
    assign bus.alucontrol = aluCtl;
    assign bus.retire     = reset & (ctrl_q.retire | (ctrl_q.memWrite & bus.mem_ready));
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed bench for multicycle_controller built with TIMEOUT_CYCLES=4 so
// the timeout boundary is reachable in a few cycles. Each step drives the
// inputs after a falling edge, checks every output 1 time unit later, then
// advances to the next falling edge (one rising edge in between).
module tb_multicycle_controller;

    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    multicycle_controller_if bus();

    multicycle_controller #(
        .TIMEOUT_CYCLES (4),
        .TO_W           (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       memReq;
        logic       iord;
        logic       memWrite;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic       pcEn;
        logic [2:0] aluCtl;
        logic       retire;
        logic       fault;
    } obs_t;

    // Hand-derived expected output vectors per state / input condition
    localparam obs_t E_RESET      = '{aluCtl:3'b010, default:'0};
    localparam obs_t E_FETCH_RDY  = '{memReq:1'b1, irWrite:1'b1, aluSrcB:2'b01, pcEn:1'b1, aluCtl:3'b010, default:'0};
    localparam obs_t E_FETCH_WAIT = '{memReq:1'b1, aluSrcB:2'b01, aluCtl:3'b010, default:'0};
    localparam obs_t E_DECODE     = '{aluSrcB:2'b11, aluCtl:3'b010, default:'0};
    localparam obs_t E_MEMADR     = '{aluSrcA:1'b1, aluSrcB:2'b10, aluCtl:3'b010, default:'0};
    localparam obs_t E_MEMRD      = '{memReq:1'b1, iord:1'b1, aluCtl:3'b010, default:'0};
    localparam obs_t E_MEMWB      = '{regWrite:1'b1, memToReg:1'b1, retire:1'b1, aluCtl:3'b010, default:'0};
    localparam obs_t E_MEMWR_WAIT = '{memReq:1'b1, iord:1'b1, memWrite:1'b1, aluCtl:3'b010, default:'0};
    localparam obs_t E_MEMWR_RDY  = '{memReq:1'b1, iord:1'b1, memWrite:1'b1, retire:1'b1, aluCtl:3'b010, default:'0};
    localparam obs_t E_EXEC_SLT   = '{aluSrcA:1'b1, aluCtl:3'b111, default:'0};
    localparam obs_t E_EXEC_BAD   = '{aluSrcA:1'b1, aluCtl:3'b000, default:'0};
    localparam obs_t E_ALUWB      = '{regWrite:1'b1, regDst:1'b1, retire:1'b1, aluCtl:3'b010, default:'0};
    localparam obs_t E_BRANCH_Z1  = '{aluSrcA:1'b1, pcSrc:2'b01, pcEn:1'b1, aluCtl:3'b110, retire:1'b1, default:'0};
    localparam obs_t E_BRANCH_Z0  = '{aluSrcA:1'b1, pcSrc:2'b01, aluCtl:3'b110, retire:1'b1, default:'0};
    localparam obs_t E_ADDIEX     = '{aluSrcA:1'b1, aluSrcB:2'b10, aluCtl:3'b010, default:'0};
    localparam obs_t E_ADDIWB     = '{regWrite:1'b1, retire:1'b1, aluCtl:3'b010, default:'0};
    localparam obs_t E_JUMP       = '{pcSrc:2'b10, pcEn:1'b1, retire:1'b1, aluCtl:3'b010, default:'0};
    localparam obs_t E_HALT       = '{fault:1'b1, aluCtl:3'b010, default:'0};

    function automatic obs_t sampleOutputs();
        obs_t s;
        s.memReq   = bus.mem_req;
        s.iord     = bus.iord;
        s.memWrite = bus.memwrite;
        s.irWrite  = bus.irwrite;
        s.regDst   = bus.regdst;
        s.memToReg = bus.memtoreg;
        s.regWrite = bus.regwrite;
        s.aluSrcA  = bus.alusrca;
        s.aluSrcB  = bus.alusrcb;
        s.pcSrc    = bus.pcsrc;
        s.pcEn     = bus.pcen;
        s.aluCtl   = bus.alucontrol;
        s.retire   = bus.retire;
        s.fault    = bus.fault;
        return s;
    endfunction

    // Drive the datapath/memory inputs of the controller
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                                 input logic zero, input logic ready);
        bus.op        = op;
        bus.funct     = funct;
        bus.zero      = zero;
        bus.mem_ready = ready;
    endtask

    // Compare the full output vector against a hand-derived expectation
    task automatic checkOutput(input string tag, input obs_t expected);
        obs_t observed;
        observed = sampleOutputs();
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Check the current cycle, then move one clock forward
    task automatic step(input string tag, input obs_t expected);
        #1;
        checkOutput(tag, expected);
        @(negedge clk);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;

        // Reset held low: FETCH with ready=1 must still show no strobes
        reset = 1'b0;
        applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("reset_hold", E_RESET);
        @(negedge clk);
        reset = 1'b1;

        // lw, memory always ready: 5 cycles, retire only in MEMWB
        step("lw_fetch",  E_FETCH_RDY);
        step("lw_decode", E_DECODE);
        step("lw_memadr", E_MEMADR);
        step("lw_memrd",  E_MEMRD);
        step("lw_memwb",  E_MEMWB);

        // beq taken then not taken
        applyStimulus(6'b000100, 6'b000000, 1'b1, 1'b1);
        step("beqz1_fetch",  E_FETCH_RDY);
        step("beqz1_decode", E_DECODE);
        step("beqz1_branch", E_BRANCH_Z1);
        applyStimulus(6'b000100, 6'b000000, 1'b0, 1'b1);
        step("beqz0_fetch",  E_FETCH_RDY);
        step("beqz0_decode", E_DECODE);
        step("beqz0_branch", E_BRANCH_Z0);

        // R-type slt, then unknown funct
        applyStimulus(6'b000000, 6'b101010, 1'b0, 1'b1);
        step("slt_fetch",   E_FETCH_RDY);
        step("slt_decode",  E_DECODE);
        step("slt_execute", E_EXEC_SLT);
        step("slt_aluwb",   E_ALUWB);
        applyStimulus(6'b000000, 6'b111111, 1'b0, 1'b1);
        step("badf_fetch",   E_FETCH_RDY);
        step("badf_decode",  E_DECODE);
        step("badf_execute", E_EXEC_BAD);
        step("badf_aluwb",   E_ALUWB);

        // addi and j
        applyStimulus(6'b001000, 6'b000000, 1'b0, 1'b1);
        step("addi_fetch",  E_FETCH_RDY);
        step("addi_decode", E_DECODE);
        step("addi_ex",     E_ADDIEX);
        step("addi_wb",     E_ADDIWB);
        applyStimulus(6'b000010, 6'b000000, 1'b0, 1'b1);
        step("j_fetch",  E_FETCH_RDY);
        step("j_decode", E_DECODE);
        step("j_jump",   E_JUMP);

        // sw with 3 not-ready cycles in MEMWR: memwrite held 4 cycles
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b1);
        step("sw_fetch",  E_FETCH_RDY);
        step("sw_decode", E_DECODE);
        step("sw_memadr", E_MEMADR);
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b0);
        step("sw_wait1", E_MEMWR_WAIT);
        step("sw_wait2", E_MEMWR_WAIT);
        step("sw_wait3", E_MEMWR_WAIT);
        applyStimulus(6'b101011, 6'b000000, 1'b0, 1'b1);
        step("sw_ready", E_MEMWR_RDY);

        // Ready arrives on the 4th FETCH cycle: access completes, no fault
        applyStimulus(6'b000010, 6'b000000, 1'b0, 1'b0);
        step("to_wait1", E_FETCH_WAIT);
        step("to_wait2", E_FETCH_WAIT);
        step("to_wait3", E_FETCH_WAIT);
        applyStimulus(6'b000010, 6'b000000, 1'b0, 1'b1);
        step("to_edge_ready", E_FETCH_RDY);
        step("to_edge_decode", E_DECODE);
        step("to_edge_jump",   E_JUMP);

        // Ready stuck low 4 cycles in FETCH: HALT with fault, no mem_req
        applyStimulus(6'b000010, 6'b000000, 1'b0, 1'b0);
        step("to_stuck1", E_FETCH_WAIT);
        step("to_stuck2", E_FETCH_WAIT);
        step("to_stuck3", E_FETCH_WAIT);
        step("to_stuck4", E_FETCH_WAIT);
        step("to_halt",   E_HALT);
        applyStimulus(6'b000010, 6'b000000, 1'b0, 1'b1);
        step("to_halt_sticky", E_HALT);

        // Reset clears the fault
        reset = 1'b0;
        #1;
        checkOutput("to_reset", E_RESET);
        @(negedge clk);
        reset = 1'b1;

        // Illegal opcode goes to HALT and stays there
        applyStimulus(6'b111111, 6'b000000, 1'b0, 1'b1);
        step("ill_fetch",  E_FETCH_RDY);
        step("ill_decode", E_DECODE);
        step("ill_halt",   E_HALT);
        applyStimulus(6'b100011, 6'b000000, 1'b1, 1'b1);
        step("ill_sticky", E_HALT);

        reset = 1'b0;
        #1;
        checkOutput("ill_reset", E_RESET);
        @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of a stalled lw read
        applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b1);
        step("mid_fetch",  E_FETCH_RDY);
        step("mid_decode", E_DECODE);
        step("mid_memadr", E_MEMADR);
        applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b0);
        step("mid_memrd", E_MEMRD);
        reset = 1'b0;
        #1;
        checkOutput("mid_reset_async", E_RESET);
        @(negedge clk);
        applyStimulus(6'b100011, 6'b000000, 1'b0, 1'b1);
        #1;
        checkOutput("mid_reset_held", E_RESET);
        @(negedge clk);
        reset = 1'b1;
        step("mid_refetch",  E_FETCH_RDY);
        step("mid_redecode", E_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
